// File: rtl/button_debounce_multi.sv
// button_debounce_multi
//
// Multi-channel push-button conditioner. Each channel runs its own 2-flop
// synchroniser and debounce FSM. A new level is accepted only after DEB_CYCLES
// consecutive stable synchronised samples. The block emits a registered stable
// level and one-cycle press/release pulses.
//
// Optional feature macro: LONG_PRESS_EN
//   Defined   : btn_long pulses once per press after LONG_CYCLES of continuous
//               HIGH-state time.
//   Undefined : btn_long is tied to 0 and the HIGH-state counter holds at 0.
//
// Ports:
//   clk         in   1     system clock
//   reset       in   1     synchronous, active-high reset
//   btn_in      in   N_CH  raw asynchronous button levels, 1 = pressed
//   btn_level   out  N_CH  debounced level per channel (registered)
//   btn_press   out  N_CH  one-cycle pulse when the debounced level rises
//   btn_release out  N_CH  one-cycle pulse when the debounced level falls
//   btn_long    out  N_CH  one-cycle long-press pulse (0 without LONG_PRESS_EN)

module button_debounce_multi #(
  parameter int unsigned N_CH        = 4,
  parameter logic [19:0] DEB_CYCLES  = 20'd1_000_000,
  parameter logic [31:0] LONG_CYCLES = 32'd100_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam logic [31:0] MAX_CYC = (32'(DEB_CYCLES) > LONG_CYCLES) ? 32'(DEB_CYCLES)
                                                                    : LONG_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 32'd1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 20'd1);
`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);
  // Counter parks here after the long pulse so LONG_LAST is never revisited.
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`endif

  typedef enum logic [1:0] {
    StLow,
    StWaitHigh,
    StHigh,
    StWaitLow
  } state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
`ifdef LONG_PRESS_EN
    logic             long_q, long_d;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        state_q   <= StLow;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef LONG_PRESS_EN
        long_q    <= 1'b0;
`endif
      end else begin
        sync1_q   <= btn_in[i];
        sync2_q   <= sync1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef LONG_PRESS_EN
        long_q    <= long_d;
`endif
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef LONG_PRESS_EN
      long_d    = 1'b0;
`endif
      unique case (state_q)
        StLow: begin
          if (sync2_q) begin
            state_d = StWaitHigh;
            cnt_d   = '0;
          end
        end
        StWaitHigh: begin
          if (!sync2_q) begin
            state_d = StLow;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = StHigh;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (!sync2_q) begin
            state_d = StWaitLow;
            cnt_d   = '0;
          end else begin
`ifdef LONG_PRESS_EN
            if (cnt_q == LONG_LAST) begin
              long_d = 1'b1;
            end
            if (cnt_q != LONG_SAT) begin
              cnt_d = cnt_q + 1'b1;
            end
`else
            cnt_d = '0;
`endif
          end
        end
        StWaitLow: begin
          if (sync2_q) begin
            // Bounce back: long-press timing restarts from zero.
            state_d = StHigh;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = StLow;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StLow;
          cnt_d   = '0;
        end
      endcase
      // Level follows the next state so it lines up with the pulses.
      level_d = (state_d == StHigh) || (state_d == StWaitLow);
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
`ifdef LONG_PRESS_EN
    assign btn_long[i]    = long_q;
`else
    assign btn_long[i]    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi with DEB_CYCLES=4, LONG_CYCLES=10,
// N_CH=4. Edge numbering: edge 0 is the first clock edge sampling the new
// btn_in value; outputs are sampled 1 time unit after each rising edge.

module tb_button_debounce_multi;

  localparam int unsigned N_CH = 4;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_long;

  int errors;
  int checks;

  button_debounce_multi #(
    .N_CH       (N_CH),
    .DEB_CYCLES (20'd4),
    .LONG_CYCLES(32'd10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N_CH-1:0] exp_level;
  logic [N_CH-1:0] exp_pulse;
  logic            exp_long;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    btn_in = '0;
    step();
    step();
    check("reset_level",   32'(btn_level),   32'h0);
    check("reset_press",   32'(btn_press),   32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    check("reset_long",    32'(btn_long),    32'h0);
    reset = 1'b0;
    step();

    // 1. Clean press on channel 0, then clean release.
    btn_in = 4'b0001;
    for (int e = 0; e <= 8; e++) begin
      step();
      exp_level = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_pulse = (e == 6) ? 4'b0001 : 4'b0000;
      check($sformatf("t1_level_e%0d", e), 32'(btn_level), 32'(exp_level));
      check($sformatf("t1_press_e%0d", e), 32'(btn_press), 32'(exp_pulse));
      check($sformatf("t1_rel_e%0d", e),   32'(btn_release), 32'h0);
    end
    btn_in = 4'b0000;
    for (int e = 0; e <= 8; e++) begin
      step();
      exp_level = (e < 6) ? 4'b0001 : 4'b0000;
      exp_pulse = (e == 6) ? 4'b0001 : 4'b0000;
      check($sformatf("t1r_level_e%0d", e), 32'(btn_level), 32'(exp_level));
      check($sformatf("t1r_rel_e%0d", e),   32'(btn_release), 32'(exp_pulse));
      check($sformatf("t1r_press_e%0d", e), 32'(btn_press), 32'h0);
    end

    // 2. Three-cycle glitch on channel 1 is rejected.
    btn_in = 4'b0010;
    for (int e = 0; e < 3; e++) begin
      step();
      check($sformatf("t2_level_hi%0d", e), 32'(btn_level), 32'h0);
    end
    btn_in = 4'b0000;
    for (int e = 0; e < 12; e++) begin
      step();
      check($sformatf("t2_level_e%0d", e), 32'(btn_level), 32'h0);
      check($sformatf("t2_press_e%0d", e), 32'(btn_press), 32'h0);
    end

    // 3. Channel 2 pressed, then bounces on release.
    btn_in = 4'b0100;
    for (int e = 0; e < 10; e++) step();
    check("t3_high", 32'(btn_level), 32'h4);
    btn_in = 4'b0000;
    step();
    check("t3_bounce0", 32'(btn_level), 32'h4);
    step();
    check("t3_bounce1", 32'(btn_level), 32'h4);
    btn_in = 4'b0100;
    step();
    check("t3_bounce2", 32'(btn_level), 32'h4);
    btn_in = 4'b0000;
    for (int e = 0; e <= 9; e++) begin
      step();
      exp_level = (e < 6) ? 4'b0100 : 4'b0000;
      exp_pulse = (e == 6) ? 4'b0100 : 4'b0000;
      check($sformatf("t3_level_e%0d", e), 32'(btn_level),   32'(exp_level));
      check($sformatf("t3_rel_e%0d", e),   32'(btn_release), 32'(exp_pulse));
    end

    // 4. All channels pressed together.
    btn_in = 4'b1111;
    for (int e = 0; e <= 8; e++) begin
      step();
      exp_level = (e >= 6) ? 4'b1111 : 4'b0000;
      exp_pulse = (e == 6) ? 4'b1111 : 4'b0000;
      check($sformatf("t4_level_e%0d", e), 32'(btn_level), 32'(exp_level));
      check($sformatf("t4_press_e%0d", e), 32'(btn_press), 32'(exp_pulse));
    end
    btn_in = 4'b0000;
    for (int e = 0; e <= 8; e++) begin
      step();
      exp_pulse = (e == 6) ? 4'b1111 : 4'b0000;
      check($sformatf("t4_rel_e%0d", e), 32'(btn_release), 32'(exp_pulse));
    end

    // 5. Reset while channel 0 sits in WAIT_HIGH with cnt=2, button held.
    btn_in = 4'b0001;
    for (int e = 0; e <= 4; e++) step();
    check("t5_pre_level", 32'(btn_level), 32'h0);
    reset = 1'b1;
    step();
    check("t5_rst_level", 32'(btn_level), 32'h0);
    check("t5_rst_press", 32'(btn_press), 32'h0);
    reset = 1'b0;

    // 5/6. Re-debounce after reset, then hold for the long-press check.
    for (int e = 0; e <= 66; e++) begin
      step();
      exp_level = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_pulse = (e == 6) ? 4'b0001 : 4'b0000;
`ifdef LONG_PRESS_EN
      exp_long = (e == 16);
`else
      exp_long = 1'b0;
`endif
      check($sformatf("t5_level_e%0d", e), 32'(btn_level), 32'(exp_level));
      check($sformatf("t5_press_e%0d", e), 32'(btn_press), 32'(exp_pulse));
      check($sformatf("t6_long_e%0d", e),  32'(btn_long),  {31'd0, exp_long});
    end
    btn_in = 4'b0000;
    for (int e = 0; e <= 8; e++) begin
      step();
      exp_pulse = (e == 6) ? 4'b0001 : 4'b0000;
      check($sformatf("t6_rel_e%0d", e),  32'(btn_release), 32'(exp_pulse));
      check($sformatf("t6_long_r%0d", e), 32'(btn_long),    32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
